// File: rtl/life_pkg.sv
// Shared constants and the scanner state encoding, common to the life matrix,
// cell and grid scanner blocks.
package life_pkg;

  localparam int GRID_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/popcount_row.sv
// Combinational population count of one grid row.
module popcount_row
  import life_pkg::*;
#(
  parameter int N = GRID_N
) (
  input  logic [N-1:0]         row,
  output logic [$clog2(N):0]   count
);

  localparam int CW = $clog2(N) + 1;

  // NOTE: a combinational block assigns every output before any branch or loop,
  // so no path can leave a value unassigned and infer a latch.
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + {{(CW-1){1'b0}}, row[i]};
    end
  end

endmodule

// File: rtl/grid_scanner.sv
// Snapshots the life grid on a trigger and streams it one row per handshake,
// reporting the frame population and flagging triggers that arrive while busy.
module grid_scanner
  import life_pkg::*;
#(
  parameter int AUTO = 0,
  parameter int N    = GRID_N
) (
  input  logic                   clk,
  input  logic                   _rst,
  input  logic [N*N-1:0]         grid_flat,
  input  logic                   gen_tick,
  input  logic                   start,
  input  logic                   row_ready,
  input  logic                   clr_ovr,
  output logic                   row_valid,
  output logic [N-1:0]           row_data,
  output logic [$clog2(N)-1:0]   row_idx,
  output logic                   busy,
  output logic                   frame_done,
  output logic [$clog2(N*N):0]   live_count,
  output logic                   overrun
);

  localparam int IW = $clog2(N);
  localparam int LW = $clog2(N*N) + 1;
  localparam int PW = $clog2(N) + 1;

  scan_state_e      state, state_nxt;
  logic [N*N-1:0]   shadow;
  logic [LW-1:0]    acc;
  logic [PW-1:0]    row_pop;
  logic             trigger;
  logic             last_row;

  // start and gen_tick on the same edge collapse into one trigger.
  assign trigger  = start | ((AUTO != 0) & gen_tick);
  assign last_row = (row_idx == IW'(N-1));

  popcount_row #(.N(N)) u_popcount (
    .row   (row_data),
    .count (row_pop)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the result is independent of block ordering.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    row_valid  = 1'b0;
    row_data   = '0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = SEND;
      end
      SEND: begin
        row_valid = 1'b1;
        busy      = 1'b1;
        row_data  = shadow[int'(row_idx)*N +: N];
        if (row_ready && last_row) state_nxt = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the shadow grid is a plain register bank, not a RAM, so it is reset
  // along with the rest of the datapath and never streams stale contents.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      shadow     <= '0;
      row_idx    <= '0;
      acc        <= '0;
      live_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (state == IDLE && trigger) begin
        shadow  <= grid_flat;
        row_idx <= '0;
        acc     <= '0;
      end
      if (state == SEND && row_ready) begin
        acc     <= acc + {{(LW-PW){1'b0}}, row_pop};
        row_idx <= last_row ? '0 : row_idx + 1'b1;
      end
      if (state == DONE) begin
        live_count <= acc;
      end
      // A late trigger wins over a simultaneous clear.
      if (trigger && state != IDLE) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_grid_scanner.sv
// Directed bench for grid_scanner (AUTO=1, N=8) with hand-computed row data,
// frame populations and flag behaviour.
module tb_grid_scanner;

  logic        clk = 1'b0;
  logic        _rst;
  logic [63:0] grid_flat;
  logic        gen_tick;
  logic        start;
  logic        row_ready;
  logic        clr_ovr;
  logic        row_valid;
  logic [7:0]  row_data;
  logic [2:0]  row_idx;
  logic        busy;
  logic        frame_done;
  logic [6:0]  live_count;
  logic        overrun;

  int n_tests = 0;
  int n_fail  = 0;

  grid_scanner #(.AUTO(1), .N(8)) dut (
    .clk        (clk),
    ._rst       (_rst),
    .grid_flat  (grid_flat),
    .gen_tick   (gen_tick),
    .start      (start),
    .row_ready  (row_ready),
    .clr_ovr    (clr_ovr),
    .row_valid  (row_valid),
    .row_data   (row_data),
    .row_idx    (row_idx),
    .busy       (busy),
    .frame_done (frame_done),
    .live_count (live_count),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic trigger(input logic [63:0] g, input logic with_tick);
    grid_flat = g;
    start     = 1'b1;
    gen_tick  = with_tick;
    step();
    start     = 1'b0;
    gen_tick  = 1'b0;
  endtask

  // Called on the falling edge after the trigger edge; ends in IDLE after DONE.
  task automatic scan_frame(input string name, input logic [63:0] snap, input int exp_live,
                            input int prev_live, input int stall_row, input int stall_cyc,
                            input int tick_row, input logic tick_clr);
    logic [7:0] exp_row;
    for (int r = 0; r < 8; r++) begin
      exp_row = snap[r*8 +: 8];
      if (r == stall_row) begin
        row_ready = 1'b0;
        for (int s = 0; s < stall_cyc; s++) begin
          check($sformatf("%s stall%0d data", name, s), row_data, exp_row);
          check($sformatf("%s stall%0d idx", name, s), row_idx, r);
          check($sformatf("%s stall%0d valid", name, s), row_valid, 1);
          step();
        end
        row_ready = 1'b1;
      end
      if (r == tick_row) begin
        gen_tick = 1'b1;
        clr_ovr  = tick_clr;
      end
      check($sformatf("%s row%0d valid", name, r), row_valid, 1);
      check($sformatf("%s row%0d idx", name, r), row_idx, r);
      check($sformatf("%s row%0d data", name, r), row_data, exp_row);
      check($sformatf("%s row%0d busy", name, r), busy, 1);
      check($sformatf("%s row%0d done", name, r), frame_done, 0);
      check($sformatf("%s row%0d live held", name, r), live_count, prev_live);
      step();
      gen_tick = 1'b0;
      clr_ovr  = 1'b0;
    end
    check({name, " done pulse"}, frame_done, 1);
    check({name, " done valid"}, row_valid, 0);
    check({name, " done busy"}, busy, 1);
    check({name, " done idx wrap"}, row_idx, 0);
    check({name, " done live held"}, live_count, prev_live);
    step();
    check({name, " idle done"}, frame_done, 0);
    check({name, " idle busy"}, busy, 0);
    check({name, " idle valid"}, row_valid, 0);
    check({name, " live_count"}, live_count, exp_live);
  endtask

  initial begin
    _rst      = 1'b0;
    grid_flat = '0;
    gen_tick  = 1'b0;
    start     = 1'b0;
    row_ready = 1'b1;
    clr_ovr   = 1'b0;
    #2;
    check("reset valid", row_valid, 0);
    check("reset busy", busy, 0);
    check("reset data", row_data, 0);
    check("reset idx", row_idx, 0);
    check("reset live", live_count, 0);
    check("reset ovr", overrun, 0);
    step();
    _rst = 1'b1;
    step();

    // Basic scan: one full row, frame_done on the ninth cycle after trigger.
    trigger(64'h0000_0000_0000_00FF, 1'b0);
    scan_frame("basic", 64'h0000_0000_0000_00FF, 8, 0, -1, 0, -1, 1'b0);

    // Backpressure on row 2 for three cycles.
    trigger(64'h8142_2418_1824_4281, 1'b0);
    scan_frame("bp", 64'h8142_2418_1824_4281, 16, 8, 2, 3, -1, 1'b0);

    // Snapshot isolation: live grid changes after capture.
    trigger(64'h0, 1'b0);
    grid_flat = '1;
    scan_frame("snap", 64'h0, 0, 16, -1, 0, -1, 1'b0);

    // Overrun: gen_tick during row 4 must not disturb the frame.
    check("ovr before", overrun, 0);
    trigger(64'hF0F0_0000_0000_0001, 1'b0);
    scan_frame("ovr", 64'hF0F0_0000_0000_0001, 9, 0, -1, 0, 4, 1'b0);
    check("ovr set", overrun, 1);
    trigger(64'hF0F0_0000_0000_0001, 1'b0);
    scan_frame("ovr2", 64'hF0F0_0000_0000_0001, 9, 9, -1, 0, 1, 1'b1);
    check("ovr set beats clr", overrun, 1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("ovr cleared", overrun, 0);

    // Reset mid-scan during row 5.
    trigger(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    for (int r = 0; r < 5; r++) step();
    check("rst pre idx", row_idx, 5);
    _rst = 1'b0;
    #1;
    check("rst mid valid", row_valid, 0);
    check("rst mid busy", busy, 0);
    check("rst mid data", row_data, 0);
    check("rst mid idx", row_idx, 0);
    check("rst mid live", live_count, 0);
    check("rst mid done", frame_done, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst hold%0d done", i), frame_done, 0);
    end
    _rst = 1'b1;
    trigger(64'h8142_2418_1824_4281, 1'b0);
    scan_frame("post rst", 64'h8142_2418_1824_4281, 16, 0, -1, 0, -1, 1'b0);

    // Back-to-back: start+gen_tick together, then trigger right after DONE.
    trigger(64'h0102_0408_1020_4080, 1'b1);
    scan_frame("b2b A", 64'h0102_0408_1020_4080, 8, 16, -1, 0, -1, 1'b0);
    check("b2b A single trigger", overrun, 0);
    trigger(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    scan_frame("b2b B", 64'hFFFF_FFFF_FFFF_FFFF, 64, 8, -1, 0, -1, 1'b0);
    check("b2b B ovr", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_scanner.md
GRID_SCANNER -- requirements
Module: grid_scanner

Interface
REQ-001 SHALL have parameter AUTO, default 0: 1 = every gen_tick pulse also triggers a scan.
REQ-002 SHALL have parameter N, default 8: grid edge length (rows = columns = N).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port _rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port grid_flat  input  N*N  live grid, row-major; bit r*N+c is cell [r][c], 1 = alive.
REQ-006 SHALL have port gen_tick  input  1  one-cycle pulse each time the matrix advances a generation.
REQ-007 SHALL have port start  input  1  one-cycle scan request.
REQ-008 SHALL have port row_ready  input  1  sink accepts the current row.
REQ-009 SHALL have port clr_ovr  input  1  clears the overrun flag.
REQ-010 SHALL have port row_valid  output  1  row_data/row_idx are valid.
REQ-011 SHALL have port row_data  output  N  snapshot row; bit c is cell [row_idx][c].
REQ-012 SHALL have port row_idx  output  clog2(N)  index of the row being presented.
REQ-013 SHALL have port busy  output  1  high in SEND and DONE.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last row transfers.
REQ-015 SHALL have port live_count  output  clog2(N*N)+1  population of the scanned frame.
REQ-016 SHALL have port overrun  output  1  sticky flag: a trigger arrived while busy.

Function
REQ-017 SHALL implement the FSM states IDLE, SEND and DONE.
REQ-018 SHALL define trigger = start | (AUTO & gen_tick).
REQ-019 SHALL, on trigger in IDLE: capture grid_flat into a shadow register on that edge, clear row_idx and the live accumulator, and enter SEND.
REQ-020 SHALL assert row_valid the cycle after the trigger (one-cycle latency).
REQ-021 SHALL, in SEND, drive row_valid=1 and row_data = shadow row row_idx.
REQ-022 SHALL hold row_data and row_idx stable while row_valid & !row_ready.
REQ-023 SHALL treat row_valid & row_ready as a transfer: add popcount(row_data) to the accumulator and increment row_idx.
REQ-024 SHALL, on the transfer of row N-1, enter DONE; row_idx wraps to 0.
REQ-025 SHALL, in DONE, hold row_valid=0 and frame_done=1 for exactly one cycle, load live_count from the accumulator on that edge, then return to IDLE.
REQ-026 SHALL keep live_count at the last completed frame's value until the next frame completes.
REQ-027 SHALL ignore changes to grid_flat after capture; the streamed frame is the snapshot only.
REQ-028 SHALL ignore a trigger in SEND or DONE and set overrun on that edge.
REQ-029 SHALL give set priority over clr_ovr when both occur on the same edge.
REQ-030 SHALL count start and gen_tick asserted together (AUTO=1) as a single trigger.
REQ-031 SHALL accept a trigger in IDLE on the edge immediately after DONE (back-to-back frames, one idle cycle minimum).
REQ-032 SHALL, with row_ready held high, complete a frame in N+1 cycles after the trigger edge.

Reset
REQ-033 SHALL, on _rst low and independent of clk, force: state=IDLE, row_valid=0, row_data=0, row_idx=0, busy=0, frame_done=0, live_count=0, overrun=0, shadow=0.
REQ-034 SHALL, on reset mid-scan, abandon the frame with no frame_done, and SHALL accept a trigger on the first clk edge after _rst deasserts.

Structure
REQ-035 SHALL take the shared constants GRID_N=8 and the state encoding from the shared life_pkg package, common with the matrix and cell.
REQ-036 SHALL place the row population count in one sub-module, popcount_row: combinational, N in, clog2(N)+1 out.

Verification
REQ-037 SHALL verify basic scan: start=1 with the 8x8 grid 0x0000_0000_0000_00FF and row_ready=1 -> row 0 = 0xFF, rows 1-7 = 0x00, frame_done at cycle 9, live_count=8.
REQ-038 SHALL verify backpressure: row_ready=0 for 3 cycles on row 2 of the grid 0x8142_2418_1824_4281 -> row_data=0x24 held stable for 4 cycles, row_idx=2, live_count=16.
REQ-039 SHALL verify snapshot isolation: flip grid_flat to all-ones after the trigger -> all-zero frame streamed, live_count=0.
REQ-040 SHALL verify overrun: AUTO=1, gen_tick during row 4 -> scan unaffected, overrun=1; then clr_ovr and gen_tick on the same edge while busy -> overrun stays 1.
REQ-041 SHALL verify reset mid-scan: _rst low during row 5 -> all outputs 0 immediately, no frame_done; start after release -> full frame from row 0.
REQ-042 SHALL verify back-to-back scans: trigger on the edge after DONE -> second frame begins, row_valid one cycle later, live_count updated at each DONE.
